// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants and the message padder state encoding.
package sha256_pkg;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int LEN_HI_IDX = 14;
    localparam int LEN_LO_IDX = 15;
    typedef enum logic [2:0] {S_DATA, S_PAD80, S_ZERO, S_LEN_HI, S_LEN_LO} pad_state_t;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
endpackage

// File: rtl/sha256_byte_term.sv
// sha256_byte_term: masks the final message word and inserts the 0x80 terminator byte.
module sha256_byte_term (
    input  logic [31:0] i_data,
    input  logic [2:0]  i_bytes,
    output logic [31:0] o_word,
    output logic [2:0]  o_nbytes,
    output logic        o_full
);
    logic [2:0] w_n;
    logic [5:0] w_sh;
    assign w_n = (i_bytes == 3'd0 || i_bytes > 3'd4) ? 3'd4 : i_bytes;
    assign w_sh = {w_n, 3'b000};
    assign o_full = w_n == 3'd4;
    assign o_nbytes = w_n;
    assign o_word = o_full ? i_data : (i_data & ~(32'hFFFF_FFFF >> w_sh)) | (32'h8000_0000 >> w_sh);
endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streams a raw message out as FIPS 180-4 padded 512-bit blocks of 32-bit words.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int          LEN_W      = 64,
    parameter int unsigned MAX_BLOCKS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_in_data,
    input  logic        i_in_valid,
    input  logic        i_in_last,
    input  logic [2:0]  i_in_bytes,
    output logic        o_in_ready,
    output logic [31:0] o_out_word,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [3:0]  o_out_idx,
    output logic        o_out_blk_last,
    output logic        o_out_msg_last
);
    pad_state_t       r_state, w_nst, w_after;
    logic [31:0]      r_word, w_word, w_term, r_blocks;
    logic             r_valid, r_blk_last, r_msg_last, w_last, w_full, w_adv, w_acc, w_load, w_lim;
    logic [3:0]       r_idx, r_pos;
    logic [2:0]       w_nbytes;
    logic [LEN_W-1:0] r_cnt;
    logic [63:0]      w_len;

    sha256_byte_term u_term (
        .i_data   (i_in_data),
        .i_bytes  (i_in_bytes),
        .o_word   (w_term),
        .o_nbytes (w_nbytes),
        .o_full   (w_full)
    );

    assign w_adv = !r_valid || i_out_ready;
    assign w_lim = (MAX_BLOCKS != 0) && (r_blocks + 32'd1 > 32'(MAX_BLOCKS));
    assign o_in_ready = !rst && r_state == S_DATA && w_adv && !w_lim;
    assign w_acc = i_in_valid && o_in_ready;
    assign w_load = (r_state == S_DATA) ? w_acc : w_adv;
    assign w_len = 64'(r_cnt);
    // r_pos is the index the next loaded word will carry; the length must start at LEN_HI_IDX
    assign w_after = (r_pos == 4'(LEN_HI_IDX - 1)) ? S_LEN_HI : S_ZERO;

    always_comb begin
        w_nst = r_state;
        w_word = '0;
        w_last = 1'b0;
        case (r_state)
            S_DATA: begin
                w_word = i_in_last ? w_term : i_in_data;
                w_nst = !i_in_last ? S_DATA : w_full ? S_PAD80 : w_after;
            end
            S_PAD80: begin
                w_word = 32'h8000_0000;
                w_nst = w_after;
            end
            S_ZERO: w_nst = w_after;
            S_LEN_HI: begin
                w_word = w_len[63:32];
                w_nst = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_word = w_len[31:0];
                w_last = 1'b1;
                w_nst = S_DATA;
            end
            default: w_nst = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DATA;
            r_word <= '0;
            r_valid <= 1'b0;
            r_idx <= '0;
            r_pos <= '0;
            r_blk_last <= 1'b0;
            r_msg_last <= 1'b0;
            r_cnt <= '0;
            r_blocks <= '0;
        end else begin
            if (w_load) begin
                r_state <= w_nst;
                r_word <= w_word;
                r_idx <= r_pos;
                r_pos <= r_pos + 4'd1;
                r_blk_last <= r_pos == 4'(LEN_LO_IDX);
                r_msg_last <= w_last;
            end
            if (w_adv) r_valid <= w_load;
            if (w_acc) r_cnt <= r_cnt + (i_in_last ? LEN_W'({w_nbytes, 3'b000}) : LEN_W'(32));
            else if (w_load && w_last) r_cnt <= '0;
            if (r_valid && i_out_ready) r_blocks <= r_msg_last ? '0 : r_blocks + 32'(r_blk_last);
        end
    end

    assign o_out_word = r_word;
    assign o_out_valid = r_valid;
    assign o_out_idx = r_idx;
    assign o_out_blk_last = r_blk_last;
    assign o_out_msg_last = r_msg_last;
endmodule
